// File: rtl/hex_digit_counter_pkg.sv
// Shared speed encodings and step-period helper for the hex digit counter.
package hex_digit_counter_pkg;

  localparam logic [1:0] SPEED_FAST = 2'b00;
  localparam logic [1:0] SPEED_1S   = 2'b01;
  localparam logic [1:0] SPEED_2S   = 2'b10;
  localparam logic [1:0] SPEED_4S   = 2'b11;

  // Clocks between successive steps; 64-bit so 4*CLK_FREQ never overflows.
  function automatic logic [63:0] period_of(logic [1:0] speed, logic [63:0] clk_freq);
    case (speed)
      SPEED_FAST: period_of = 64'd1;
      SPEED_1S:   period_of = clk_freq;
      SPEED_2S:   period_of = clk_freq << 1;
      default:    period_of = clk_freq << 2;
    endcase
  endfunction

endpackage

// File: rtl/hex_digit_counter_rate_divider.sv
// Step-rate down-counter with registered speed copy and speed-change restart.
module rate_divider
  import hex_digit_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       reload,
  output logic       enable_out
);

  localparam int DIV_W = $clog2(64'(CLK_FREQ) * 64'd4);

  logic [DIV_W-1:0] count;
  logic [1:0]       speed_q;
  logic [DIV_W-1:0] start_new;
  logic [DIV_W-1:0] start_cur;
  logic             speed_chg;

  assign start_new  = DIV_W'(period_of(speed,   64'(CLK_FREQ)) - 64'd1);
  assign start_cur  = DIV_W'(period_of(speed_q, 64'(CLK_FREQ)) - 64'd1);
  assign speed_chg  = (speed != speed_q);
  assign enable_out = (count == '0) && !pause && !reload && !speed_chg;

  // A load or speed change restarts the period from the live speed input.
  always_ff @(posedge clock) begin
    if (reset || reload || speed_chg) begin
      count   <= start_new;
      speed_q <= speed;
    end else if (!pause) begin
      if (count == '0)
        count <= start_cur;
      else
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/hex_digit_counter.sv
// Multi-digit hex up/down counter with rate select, pause, parallel load, tick and wrap pulses.
module hex_digit_counter
  import hex_digit_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned NUM_DIGITS = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              speed,
  input  logic                    up_down,
  input  logic                    pause,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    wrap
);

  localparam int W = 4 * NUM_DIGITS;

  logic         step_en;
  logic [W:0]   step_res;

  // Returns {rollover, next value}; rollover is all-F going up or zero going down.
  function automatic logic [W:0] step_digits(logic [W-1:0] d, logic up);
    if (up)
      step_digits = {&d, d + 1'b1};
    else
      step_digits = {~|d, d - 1'b1};
  endfunction

  rate_divider #(
    .CLK_FREQ (CLK_FREQ)
  ) u_rate_divider (
    .clock      (clock),
    .reset      (reset),
    .speed      (speed),
    .pause      (pause),
    .reload     (load),
    .enable_out (step_en)
  );

  assign step_res = step_digits(digits, up_down);

  always_ff @(posedge clock) begin
    if (reset) begin
      digits <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (load) begin
      digits <= load_value;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (step_en) begin
      digits <= step_res[W-1:0];
      tick   <= 1'b1;
      wrap   <= step_res[W];
    end else begin
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Randomized and directed bench for hex_digit_counter against a clocks-until-step reference model.
module tb_hex_digit_counter;

  localparam int CF = 4;
  localparam int ND = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      speed = 2'b01;
  logic            up_down = 1'b1;
  logic            pause = 1'b0;
  logic            load = 1'b0;
  logic [4*ND-1:0] load_value = '0;
  logic [4*ND-1:0] digits;
  logic            tick;
  logic            wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: count value, clocks remaining until the next step, latched speed.
  int         m_val;
  int         m_rem;
  logic [1:0] m_spd;
  bit         m_tick;
  bit         m_wrap;

  hex_digit_counter #(
    .CLK_FREQ   (CF),
    .NUM_DIGITS (ND)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .speed      (speed),
    .up_down    (up_down),
    .pause      (pause),
    .load       (load),
    .load_value (load_value),
    .digits     (digits),
    .tick       (tick),
    .wrap       (wrap)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int p_of(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return CF;
      2'b10:   return 2 * CF;
      default: return 4 * CF;
    endcase
  endfunction

  task automatic model_edge();
    m_tick = 0;
    m_wrap = 0;
    if (reset) begin
      m_val = 0;
      m_rem = p_of(speed);
      m_spd = speed;
    end else if (load) begin
      m_val = int'(load_value);
      m_rem = p_of(speed);
      m_spd = speed;
    end else if (speed != m_spd) begin
      m_rem = p_of(speed);
      m_spd = speed;
    end else if (!pause) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_rem  = p_of(m_spd);
        m_tick = 1;
        if (up_down) begin
          m_wrap = (m_val == 255);
          m_val  = (m_val + 1) % 256;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 255) % 256;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    chk("digits", 32'(digits), 32'(m_val));
    chk("tick",   32'(tick),   32'(m_tick));
    chk("wrap",   32'(wrap),   32'(m_wrap));
  endtask

  initial begin
    m_val = 0; m_rem = 1; m_spd = 2'b00; m_tick = 0; m_wrap = 0;

    // Reset then count at speed 01: one step every 4 clocks.
    #1;
    cyc();
    chk("reset_digits", 32'(digits), 32'h00);
    chk("reset_tick",   32'(tick),   32'h0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("hold_before_first", 32'(digits), 32'h00);
    cyc();
    chk("first_step", 32'(digits), 32'h01);
    chk("first_tick", 32'(tick),   32'h1);
    repeat (4) cyc();
    chk("second_step", 32'(digits), 32'h02);
    repeat (4) cyc();
    chk("third_step", 32'(digits), 32'h03);

    // Load FE at full speed, roll over upward.
    load = 1'b1; load_value = 8'hFE; speed = 2'b00;
    cyc();
    chk("load_fe", 32'(digits), 32'hFE);
    load = 1'b0;
    cyc();
    chk("up_ff", 32'(digits), 32'hFF);
    cyc();
    chk("up_wrap_val", 32'(digits), 32'h00);
    chk("up_wrap",     32'(wrap),   32'h1);
    cyc();
    chk("up_after_wrap", 32'(wrap), 32'h0);

    // Down through zero, then back up through all-F.
    up_down = 1'b0;
    cyc();
    cyc();
    chk("down_wrap_val", 32'(digits), 32'hFF);
    chk("down_wrap",     32'(wrap),   32'h1);
    up_down = 1'b1;
    cyc();
    chk("flip_wrap_val", 32'(digits), 32'h00);
    chk("flip_wrap",     32'(wrap),   32'h1);

    // Speed 10, pause mid-period, then resume.
    speed = 2'b10;
    repeat (3) cyc();
    pause = 1'b1;
    repeat (5) begin
      cyc();
      chk("pause_tick", 32'(tick), 32'h0);
    end
    pause = 1'b0;
    repeat (5) cyc();
    chk("resume_no_step", 32'(digits), 32'h00);
    cyc();
    chk("resume_step", 32'(digits), 32'h01);

    // Speed change mid-period restarts the divider at the new rate.
    speed = 2'b01;
    repeat (3) cyc();
    speed = 2'b11;
    cyc();
    chk("chg_no_tick", 32'(tick), 32'h0);
    repeat (15) cyc();
    chk("chg_no_step", 32'(digits), 32'h01);
    cyc();
    chk("chg_step", 32'(digits), 32'h02);

    // Load in the same cycle a step is due.
    speed = 2'b00;
    cyc();
    load = 1'b1; load_value = 8'h5A;
    cyc();
    chk("load_wins", 32'(digits), 32'h5A);
    chk("load_tick", 32'(tick),   32'h0);

    // Reset mid-period discards the partial count.
    speed = 2'b01; load_value = 8'h3C;
    cyc();
    load = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    chk("mid_reset", 32'(digits), 32'h00);
    reset = 1'b0;
    repeat (3) cyc();
    cyc();
    chk("post_reset_step", 32'(digits), 32'h01);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load       = ($urandom_range(0, 23) == 0);
      load_value = 8'($urandom);
      pause      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) up_down = ~up_down;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
